microwave_ctrl_param: RTL and testbench

Parametrised successor to the team's microwave top. It integrates keypad digit entry, a BCD MM:SS countdown, the magnetron interlock, a 10-step power level (duty cycling) and a completion beeper into one sequential controller. The minutes-digit count and tick divider are configurable. Outputs are raw BCD digits; the existing 7-segment decoders drive the display downstream.

---
 rtl/microwave_ctrl_param.sv | 221 ++++++++++++++++++++++
 tb/tb_microwave_ctrl_param.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/microwave_ctrl_param.sv
// Microwave controller: keypad time/power entry, BCD MM:SS countdown, door interlock,
// 10-step duty-cycled power and a completion beeper.
//
// Ports:
//   clk          system clock, rising edge
//   clearn       asynchronous active-low reset
//   keypad       one-hot digit keys (bit k = digit k), level, active-high
//   startn       start button, level, active-low
//   stopn        stop/cancel button, level, active-low
//   powern       power-set button, level, active-low
//   door_closed  1 = door closed
//   time_bcd     BCD time: [3:0] sec ones, [7:4] sec tens, upper nibbles minutes (LS first)
//   power_level  current power 1..10
//   mag_on       magnetron enable (drops combinationally when the door opens)
//   beep         completion buzzer
//   state        0 IDLE, 1 ENTRY, 2 COOK, 3 PAUSED, 4 DONE
module microwave_ctrl_param #(
  parameter int unsigned CLK_DIV    = 50000000,
  parameter int unsigned MIN_DIGITS = 2,
  parameter int unsigned BEEP_SECS  = 3
) (
  input  logic                        clk,
  input  logic                        clearn,
  input  logic [9:0]                  keypad,
  input  logic                        startn,
  input  logic                        stopn,
  input  logic                        powern,
  input  logic                        door_closed,
  output logic [4*(MIN_DIGITS+2)-1:0] time_bcd,
  output logic [3:0]                  power_level,
  output logic                        mag_on,
  output logic                        beep,
  output logic [2:0]                  state
);

  localparam int unsigned NumDigits = MIN_DIGITS + 2;
  localparam int unsigned TimeW     = 4 * NumDigits;
  localparam int unsigned TickW     = $clog2(CLK_DIV);
  localparam int unsigned BeepW     = $clog2(BEEP_SECS + 1);
  localparam logic [TickW-1:0] TickLast = TickW'(CLK_DIV - 1);
  localparam logic [BeepW-1:0] BeepLast = BeepW'(BEEP_SECS - 1);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StEntry  = 3'd1,
    StCook   = 3'd2,
    StPaused = 3'd3,
    StDone   = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [TimeW-1:0]  time_q, time_d;
  logic [3:0]        power_q, power_d;
  logic              pending_q, pending_d;
  logic [TickW-1:0]  tick_q, tick_d;
  logic [3:0]        duty_q, duty_d;
  logic [BeepW-1:0]  beep_cnt_q, beep_cnt_d;
  logic              beep_q, beep_d;

  // Previous input levels for press-edge detection; reset to the released value.
  logic [9:0]        key_prev_q;
  logic              start_prev_q, stop_prev_q, power_prev_q;

  logic [9:0]        key_edge;
  logic              key_valid;
  logic [3:0]        digit;
  logic              start_press, stop_press, power_press, any_press;
  logic              tick;
  logic [TimeW-1:0]  time_dec;

  assign key_edge    = keypad & ~key_prev_q;
  assign key_valid   = $onehot(key_edge);
  assign start_press = start_prev_q & ~startn;
  assign stop_press  = stop_prev_q & ~stopn;
  assign power_press = power_prev_q & ~powern;
  assign any_press   = (|key_edge) | start_press | stop_press | power_press;
  assign tick        = (tick_q == TickLast);

  always_comb begin
    digit = 4'd0;
    for (int k = 0; k < 10; k++) begin
      if (key_edge[k]) digit = 4'(k);
    end
  end

  // One-second BCD decrement: seconds tens wraps 0->5, every other digit 0->9.
  always_comb begin : dec_blk
    logic       borrow;
    logic [3:0] nib;
    time_dec = time_q;
    borrow   = 1'b1;
    for (int i = 0; i < NumDigits; i++) begin
      nib = time_q[4*i +: 4];
      if (borrow) begin
        if (nib == 4'd0) begin
          nib = (i == 1) ? 4'd5 : 4'd9;
        end else begin
          nib    = nib - 4'd1;
          borrow = 1'b0;
        end
      end
      time_dec[4*i +: 4] = nib;
    end
  end

  // Next-state logic. Within one cycle: door-open > stop > start > power > digit.
  always_comb begin
    state_d    = state_q;
    time_d     = time_q;
    power_d    = power_q;
    pending_d  = pending_q;
    tick_d     = tick_q;
    duty_d     = duty_q;
    beep_cnt_d = beep_cnt_q;

    unique case (state_q)
      StIdle, StEntry: begin
        if (stop_press) begin
          state_d   = StIdle;
          time_d    = '0;
          pending_d = 1'b0;
        end else if (start_press) begin
          if (door_closed && (time_q != '0)) begin
            state_d = StCook;
            tick_d  = '0;
            duty_d  = 4'd0;
          end
        end else if (power_press) begin
          pending_d = 1'b1;
        end else if (key_valid) begin
          if (pending_q) begin
            power_d   = (digit == 4'd0) ? 4'd10 : digit;
            pending_d = 1'b0;
          end else begin
            time_d  = {time_q[TimeW-5:0], digit};
            state_d = StEntry;
          end
        end
      end

      StCook: begin
        if (!door_closed || stop_press) begin
          state_d = StPaused;
        end else begin
          tick_d = tick ? '0 : tick_q + 1'b1;
          if (tick) begin
            duty_d = (duty_q == 4'd9) ? 4'd0 : duty_q + 4'd1;
            time_d = time_dec;
            if (time_dec == '0) begin
              state_d    = StDone;
              beep_cnt_d = '0;
            end
          end
        end
      end

      StPaused: begin
        if (stop_press) begin
          state_d   = StIdle;
          time_d    = '0;
          pending_d = 1'b0;
        end else if (start_press && door_closed) begin
          state_d = StCook;
        end
      end

      StDone: begin
        if (any_press) begin
          state_d = StIdle;
        end else begin
          tick_d = tick ? '0 : tick_q + 1'b1;
          if (tick) begin
            if (beep_cnt_q == BeepLast) state_d = StIdle;
            else                        beep_cnt_d = beep_cnt_q + 1'b1;
          end
        end
      end

      default: state_d = StIdle;
    endcase

    beep_d = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      state_q      <= StIdle;
      time_q       <= '0;
      power_q      <= 4'd10;
      pending_q    <= 1'b0;
      tick_q       <= '0;
      duty_q       <= 4'd0;
      beep_cnt_q   <= '0;
      beep_q       <= 1'b0;
      key_prev_q   <= '0;
      start_prev_q <= 1'b1;
      stop_prev_q  <= 1'b1;
      power_prev_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      time_q       <= time_d;
      power_q      <= power_d;
      pending_q    <= pending_d;
      tick_q       <= tick_d;
      duty_q       <= duty_d;
      beep_cnt_q   <= beep_cnt_d;
      beep_q       <= beep_d;
      key_prev_q   <= keypad;
      start_prev_q <= startn;
      stop_prev_q  <= stopn;
      power_prev_q <= powern;
    end
  end

  assign time_bcd    = time_q;
  assign power_level = power_q;
  assign beep        = beep_q;
  assign state       = state_q;
  assign mag_on      = (state_q == StCook) & (duty_q < power_q) & door_closed;

endmodule

// File: tb/tb_microwave_ctrl_param.sv
module tb_microwave_ctrl_param;

  localparam int unsigned ClkDiv    = 4;
  localparam int unsigned MinDigits = 2;
  localparam int unsigned BeepSecs  = 3;

  logic        clk = 1'b0;
  logic        clearn;
  logic [9:0]  keypad;
  logic        startn, stopn, powern, door_closed;
  logic [15:0] time_bcd;
  logic [3:0]  power_level;
  logic        mag_on, beep;
  logic [2:0]  state;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc;
  int ons;
  logic [15:0] exp_q[$];
  logic [15:0] frozen;

  microwave_ctrl_param #(
    .CLK_DIV   (ClkDiv),
    .MIN_DIGITS(MinDigits),
    .BEEP_SECS (BeepSecs)
  ) dut (
    .clk        (clk),
    .clearn     (clearn),
    .keypad     (keypad),
    .startn     (startn),
    .stopn      (stopn),
    .powern     (powern),
    .door_closed(door_closed),
    .time_bcd   (time_bcd),
    .power_level(power_level),
    .mag_on     (mag_on),
    .beep       (beep),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] enc(input int m, input int s);
    return 16'(((m / 10) << 12) | ((m % 10) << 8) | ((s / 10) << 4) | (s % 10));
  endfunction

  // Reference countdown on integer minutes/seconds; pushes n successive expected times.
  task automatic push_countdown(input int m, input int s, input int n);
    for (int i = 0; i < n; i++) begin
      if (s > 0) s--;
      else begin
        m--;
        s = 59;
      end
      exp_q.push_back(enc(m, s));
    end
  endtask

  task automatic pop_check(input string tag);
    check({tag, "_sb_nonempty"}, exp_q.size() != 0, 1);
    if (exp_q.size() != 0) check(tag, time_bcd, exp_q.pop_front());
  endtask

  task automatic wait_tick(output int cycles);
    logic [15:0] prev;
    prev   = time_bcd;
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (time_bcd == prev && cycles < 5 * ClkDiv);
    check("tick_seen", time_bcd != prev, 1);
  endtask

  task automatic press_key(input int k);
    @(negedge clk);
    keypad = 10'(1 << k);
    @(negedge clk);
    keypad = '0;
  endtask

  task automatic press_start();
    @(negedge clk);
    startn = 1'b0;
    @(negedge clk);
    startn = 1'b1;
  endtask

  task automatic press_stop();
    @(negedge clk);
    stopn = 1'b0;
    @(negedge clk);
    stopn = 1'b1;
  endtask

  task automatic press_power();
    @(negedge clk);
    powern = 1'b0;
    @(negedge clk);
    powern = 1'b1;
  endtask

  initial begin
    clearn      = 1'b0;
    keypad      = '0;
    startn      = 1'b1;
    stopn       = 1'b1;
    powern      = 1'b1;
    door_closed = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_state", state, 0);
    check("rst_time", time_bcd, 0);
    check("rst_power", power_level, 10);
    check("rst_mag", mag_on, 0);
    check("rst_beep", beep, 0);
    clearn = 1'b1;

    // 1:05 countdown to completion at full power
    press_key(1);
    press_key(0);
    press_key(5);
    check("entry_time", time_bcd, 16'h0105);
    check("entry_state", state, 1);
    press_start();
    check("cook_state", state, 2);
    push_countdown(1, 5, 65);
    for (int i = 0; i < 65; i++) begin
      wait_tick(cyc);
      check("cd1_period", cyc, ClkDiv);
      pop_check("cd1_time");
      if (i < 64) check("cd1_mag", mag_on, 1);
    end
    check("done_state", state, 4);
    check("done_beep", beep, 1);
    check("done_mag", mag_on, 0);
    cyc = 0;
    while (beep && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("beep_len", cyc, BeepSecs * ClkDiv);
    check("after_beep_state", state, 0);

    // 0:99 counts down through the unchecked seconds range
    press_key(9);
    press_key(9);
    check("t99_time", time_bcd, 16'h0099);
    press_start();
    push_countdown(0, 99, 10);
    for (int i = 0; i < 10; i++) begin
      wait_tick(cyc);
      pop_check("cd99_time");
      check("cd99_mag", mag_on, 1);
    end
    press_stop();
    check("stop_cook_state", state, 3);
    press_stop();
    check("stop_paused_state", state, 0);
    check("stop_paused_time", time_bcd, 0);

    // Power level 3 duty pattern
    press_power();
    press_key(3);
    check("power3_level", power_level, 3);
    check("power3_time", time_bcd, 0);
    press_key(2);
    press_key(0);
    check("t20_time", time_bcd, 16'h0020);
    press_start();
    push_countdown(0, 20, 10);
    ons = 0;
    check("duty0_mag", mag_on, 1);
    ons += int'(mag_on);
    for (int i = 1; i < 10; i++) begin
      wait_tick(cyc);
      pop_check("cd20_time");
      if (i == 3) check("duty3_mag", mag_on, 0);
      ons += int'(mag_on);
    end
    check("duty_on_count", ons, 3);
    wait_tick(cyc);
    pop_check("cd20_time");
    check("duty_wrap_mag", mag_on, 1);

    // Door opens mid-cook
    frozen      = time_bcd;
    door_closed = 1'b0;
    #1;
    check("door_mag_comb", mag_on, 0);
    @(negedge clk);
    check("door_paused_state", state, 3);
    check("door_paused_time", time_bcd, frozen);
    door_closed = 1'b1;
    repeat (6) @(negedge clk);
    check("door_closed_state", state, 3);
    check("door_closed_time", time_bcd, frozen);
    press_start();
    check("resume_state", state, 2);
    push_countdown(0, 10, 1);
    wait_tick(cyc);
    pop_check("resume_time");
    press_stop();
    check("stop2_state", state, 3);
    press_stop();
    check("stop2_idle", state, 0);
    check("stop2_time", time_bcd, 0);

    // Start rejected with zero time or door open; multi-key ignored
    press_start();
    check("zero_start_state", state, 0);
    check("zero_start_mag", mag_on, 0);
    press_key(7);
    check("t7_time", time_bcd, 16'h0007);
    door_closed = 1'b0;
    press_start();
    check("open_start_state", state, 1);
    check("open_start_mag", mag_on, 0);
    @(negedge clk);
    keypad = 10'h003;
    @(negedge clk);
    keypad = '0;
    @(negedge clk);
    check("multikey_time", time_bcd, 16'h0007);
    door_closed = 1'b1;
    press_start();
    check("t7_cook", state, 2);
    @(negedge clk);
    startn = 1'b0;
    stopn  = 1'b0;
    @(negedge clk);
    startn = 1'b1;
    stopn  = 1'b1;
    check("start_stop_state", state, 3);
    check("start_stop_time", time_bcd, 16'h0007);

    // Asynchronous reset mid-cook
    press_start();
    check("pre_reset_state", state, 2);
    @(negedge clk);
    #2;
    clearn = 1'b0;
    #1;
    check("areset_state", state, 0);
    check("areset_time", time_bcd, 0);
    check("areset_power", power_level, 10);
    check("areset_mag", mag_on, 0);
    check("areset_beep", beep, 0);
    @(negedge clk);
    clearn = 1'b1;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
